// File: rtl/uart_send.sv
//------------------------------------------------------------------------------
// uart_send -- buffered UART transmitter.
//
// Bytes written via dat/dat_en are queued in a small FIFO and serialised on tx
// as: start bit (0), 8 data bits LSB first, optional even parity, stop bit (1).
// Every bit lasts bit_period = clock_frequency / baudrate clock cycles. Frames
// leave the FIFO back to back with no idle gap.
//
// Optional feature: define UART_SEND_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit (11-bit frame instead of 10).
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high reset
//   dat[7:0]  in   byte to transmit, sampled when dat_en=1
//   dat_en    in   write strobe, one byte per cycle high
//   ready     out  FIFO not full
//   busy      out  frame on the line or FIFO non-empty
//   overflow  out  one-cycle pulse when a write was dropped (FIFO full)
//   tx        out  serial line, idle high, driven from a flop
//------------------------------------------------------------------------------
module uart_send #(
   parameter int baudrate        = 115200,
   parameter int clock_frequency = 100000000,
   parameter int fifo_depth      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] dat,
   input  logic       dat_en,
   output logic       ready,
   output logic       busy,
   output logic       overflow,
   output logic       tx
);

   localparam int BIT_PERIOD = clock_frequency / baudrate;
   localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int PTR_W      = $clog2(fifo_depth);
   localparam int OCC_W      = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_PERIOD - 1);
   localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(fifo_depth);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       data_q, data_d;
   logic             tx_q, tx_d;
   logic             busy_q, ready_q, overflow_q;

   logic [7:0]       mem_q [fifo_depth];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             pop, push, full, empty;

   assign full  = (occ_q == OCC_FULL);
   assign empty = (occ_q == '0);

   // A write into a full FIFO is still accepted when the same cycle pops,
   // so occupancy stays at fifo_depth and nothing is dropped.
   assign push  = dat_en && (!full || pop);
   assign occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

   //---------------------------------------------------------------------------
   // Frame FSM: next state, bit counter, and the tx level for the next cycle.
   // tx is computed from the *next* state so the registered line changes on
   // the same edge the state does.
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      pop       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               state_d = START;
               cnt_d   = CNT_RELOAD;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               cnt_d     = CNT_RELOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d = CNT_RELOAD;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_SEND_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`ifdef UART_SEND_PARITY_EN
         PARITY: begin
            if (cnt_q == '0) begin
               state_d = STOP;
               cnt_d   = CNT_RELOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`endif
         STOP: begin
            if (cnt_q == '0) begin
               // Chain straight into the next frame when more data is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  data_d  = mem_q[rd_ptr_q];
                  state_d = START;
                  cnt_d   = CNT_RELOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[bit_idx_d];
`ifdef UART_SEND_PARITY_EN
         PARITY:  tx_d = ^data_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   //---------------------------------------------------------------------------
   // State and status registers.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         data_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         overflow_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         tx_q       <= tx_d;
         busy_q     <= (state_d != IDLE) || (occ_d != '0);
         ready_q    <= (occ_d != OCC_FULL);
         overflow_q <= dat_en && full && !pop;
         occ_q      <= occ_d;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
   end

   // NOTE: the FIFO storage has no reset; an entry is only read after it has
   // been written, and the occupancy counter guards that.
   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wr_ptr_q] <= dat;
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign ready    = ready_q;
   assign overflow = overflow_q;

endmodule

// File: doc/uart_send.md
UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 SHALL have parameter baudrate, default 115200, serial bit rate in bit/s.
REQ-002 SHALL have parameter clock_frequency, default 100000000, clk frequency in Hz.
REQ-003 SHALL have parameter fifo_depth, default 16, transmit FIFO entries; power of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dat  input  8  byte to transmit; sampled when dat_en=1.
REQ-007 SHALL have port dat_en  input  1  write strobe; one byte pushed per cycle high.
REQ-008 SHALL have port ready  output  1  high when FIFO not full.
REQ-009 SHALL have port busy  output  1  high while a frame is on the line or FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 SHALL have port tx  output  1  serial line, idle high, driven from a flop.

Function
REQ-012 SHALL define bit_period = clock_frequency / baudrate (integer division) clocks per serial bit.
REQ-013 SHALL frame each byte as start bit 0, 8 data bits LSB first, [parity], one stop bit 1.
REQ-014 SHALL hold every bit on tx for exactly bit_period cycles; counter reloads bit_period-1 and counts down to 0.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty (pop that cycle); START->DATA, DATA->DATA for bits 0..6, DATA->PARITY or STOP after bit 7, PARITY->STOP, each on counter==0.
REQ-016 SHALL, at STOP counter==0, go to START with a new pop if FIFO non-empty (no idle gap), else IDLE.
REQ-017 SHALL drive tx low on the second rising edge after a dat_en cycle accepted into an empty FIFO with FSM in IDLE.
REQ-018 SHALL accept a write when dat_en=1 and FIFO not full; on write while full, SHALL discard the byte, leave FIFO unchanged, and pulse overflow the next cycle.
REQ-019 SHALL, on simultaneous write and pop with FIFO full, perform the pop and accept the write (occupancy unchanged, no overflow).
REQ-020 SHALL, on simultaneous write and pop with FIFO empty, not pop the new byte that cycle; it is popped next cycle.
REQ-021 SHALL deassert ready in the same cycle FIFO occupancy reaches fifo_depth (registered, reflecting post-edge state).
REQ-022 SHALL keep busy high from the cycle after first accepted write until STOP ends with FIFO empty.
REQ-023 SHALL wrap FIFO read/write pointers modulo fifo_depth, with a log2(fifo_depth)+1-bit occupancy counter.

Reset
REQ-024 SHALL, on reset, set tx=1, ready=1, busy=0, overflow=0, FSM=IDLE, FIFO empty, counters cleared.
REQ-025 SHALL abort any frame in progress on reset; tx high on the edge reset is sampled; queued bytes lost.
REQ-026 SHALL ignore dat_en in any cycle reset=1.

Configuration
REQ-027 SHALL, with macro UART_SEND_PARITY_EN defined, insert an even-parity bit (XOR of 8 data bits) between bit 7 and stop, frame 11 bit_periods.
REQ-028 SHALL, without UART_SEND_PARITY_EN, never enter PARITY; frame 10 bit_periods; no parity logic compiled.

Verification (clock_frequency=1000, baudrate=100, bit_period=10, fifo_depth=4 unless noted)
REQ-029 SHALL cover: reset, write 0x55 at cycle 0 -> tx low cycles 2-11, then 1,0,1,0,1,0,1,0 per 10 cycles, stop high cycles 92-101, busy low from cycle 102.
REQ-030 SHALL cover: with UART_SEND_PARITY_EN, write 0x07 -> parity bit 1 after bit 7, frame 110 cycles; 0x03 -> parity 0.
REQ-031 SHALL cover: write 0xA0,0x0F,0xFF in consecutive cycles -> three frames back-to-back, each start bit immediately after previous stop, no idle cycles.
REQ-032 SHALL cover: while first frame active, write 5 bytes -> first 4 queued, ready low after 4th, 5th dropped with overflow pulsed once, 4 queued bytes sent in order.
REQ-033 SHALL cover: assert reset mid-DATA of 0x3C -> tx=1 next edge, busy=0, ready=1, no further frame; next write 0x81 transmitted correctly.
REQ-034 SHALL cover: default parameters, write 0x00 -> each bit 868 cycles, full frame 8680 cycles.
